// File: rtl/branch_addr_bank_ctrl.sv
// branch_addr_bank_ctrl
// Round-robin controller sharing a bank of NrOfRegs branch-address registers
// between NrOfReq requesters. One operation at a time, advanced only on Tick
// (the ACK state always lasts a single clock).
// Optional bank flush/preset support is compiled in with the macro
// BRANCH_BANK_FLUSH_EN; without it flush is ignored and reg_pre stays 0.
module branch_addr_bank_ctrl #(
   parameter int NrOfBits = 32,
   parameter int NrOfReq  = 4,
   parameter int NrOfRegs = 4
) (
   input  logic                         Clock,
   input  logic                         Reset,
   input  logic                         Tick,
   input  logic [NrOfReq-1:0]           req,
   input  logic [NrOfReq-1:0]           req_we,
   input  logic [2*NrOfReq-1:0]         req_idx,
   input  logic [NrOfBits*NrOfReq-1:0]  req_data,
   output logic [NrOfReq-1:0]           gnt,
   output logic [NrOfBits-1:0]          rd_data,
   output logic                         busy,
   output logic [NrOfRegs-1:0]          reg_ce,
   output logic [NrOfBits-1:0]          reg_d,
   output logic [NrOfRegs-1:0]          reg_cs,
   input  logic [NrOfBits-1:0]          reg_q,
   output logic [NrOfRegs-1:0]          reg_pre,
   input  logic                         flush
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      ACK   = 3'd3
`ifdef BRANCH_BANK_FLUSH_EN
      , PRESET = 3'd4
`endif
   } state_t;

   state_t              state;
   logic [1:0]          ptr;       // last granted requester
   logic [1:0]          win_id;    // requester currently being serviced
   logic [NrOfRegs-1:0] ce_hold;   // registered ClockEnable pattern
   logic [1:0]          pick;
   logic                pick_ok;
   logic [1:0]          cand;

   // The bank captures on ClockEnable&Tick at the next edge, so the enable is
   // also masked by Reset directly: a reset asserted during WRITE must keep the
   // target register from capturing on that same edge.
   assign reg_ce = ce_hold & {NrOfRegs{Reset}};

`ifdef BRANCH_BANK_FLUSH_EN
   logic [NrOfRegs-1:0] pre_hold;
   assign reg_pre = pre_hold;
`else
   // Flush support is compiled out: flush has no effect and reg_pre stays 0.
   assign reg_pre = {NrOfRegs{flush}} & {NrOfRegs{1'b0}};
`endif

   // Round-robin pick: first requesting bit scanning upward from ptr+1.
   always_comb begin
      pick    = ptr;
      pick_ok = 1'b0;
      cand    = 2'd0;
      for (int k = 1; k <= NrOfReq; k++) begin
         cand = 2'((int'(ptr) + k) % NrOfReq);
         if (!pick_ok && req[cand]) begin
            pick    = cand;
            pick_ok = 1'b1;
         end
      end
   end

   // Controller FSM; every output is registered on the state transition.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state   <= IDLE;
         gnt     <= '0;
         busy    <= 1'b0;
         ce_hold <= '0;
         reg_d   <= '0;
         rd_data <= '0;
         reg_cs  <= '1;
         ptr     <= 2'(NrOfReq - 1);
         win_id  <= 2'd0;
`ifdef BRANCH_BANK_FLUSH_EN
         pre_hold <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (Tick) begin
`ifdef BRANCH_BANK_FLUSH_EN
                  if (flush) begin
                     state    <= PRESET;
                     busy     <= 1'b1;
                     pre_hold <= '1;
                  end else
`endif
                  if (pick_ok) begin
                     win_id <= pick;
                     busy   <= 1'b1;
                     if (req_we[pick]) begin
                        state   <= WRITE;
                        ce_hold <= NrOfRegs'(1) << req_idx[2*int'(pick) +: 2];
                        reg_d   <= req_data[NrOfBits*int'(pick) +: NrOfBits];
                     end else begin
                        state  <= READ;
                        reg_cs <= ~(NrOfRegs'(1) << req_idx[2*int'(pick) +: 2]);
                     end
                  end
               end
            end
            WRITE: begin
               if (Tick) begin
                  state   <= ACK;
                  ce_hold <= '0;
                  reg_d   <= '0;
                  gnt     <= NrOfReq'(1) << win_id;
               end
            end
            READ: begin
               if (Tick) begin
                  state   <= ACK;
                  rd_data <= reg_q;
                  reg_cs  <= '1;
                  gnt     <= NrOfReq'(1) << win_id;
               end
            end
            ACK: begin
               state <= IDLE;
               gnt   <= '0;
               busy  <= 1'b0;
               ptr   <= win_id;
            end
`ifdef BRANCH_BANK_FLUSH_EN
            PRESET: begin
               state    <= IDLE;
               busy     <= 1'b0;
               pre_hold <= '0;
            end
`endif
            default: begin
               state   <= IDLE;
               gnt     <= '0;
               busy    <= 1'b0;
               ce_hold <= '0;
               reg_cs  <= '1;
            end
         endcase
      end
   end

endmodule
